decode_buffer: RTL

DECODE_BUFFER -- requirements
Module: decode_buffer

---
 rtl/decode_buffer_pkg.sv | 51 +++++
 rtl/decode_buffer_lane.sv | 53 +++++
 rtl/decode_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/decode_buffer_pkg.sv
// Shared instruction format, opcode codes, buffer defaults and the decoded-entry layout.
// Defining DECODE_ILLEGAL_EN adds the illegal flag to the decoded entry.
package decode_buffer_pkg;

    localparam int INST_LEN      = 24;
    localparam int MEMI_SIZE_LOG = 8;
    localparam int RF_SIZE_LOG   = 5;
    localparam int OPC_W         = 4;
    localparam int IMM_W         = 10;
    localparam int DECODE_WIDTH  = 2;
    localparam int DECODE_DEPTH  = 8;

    // inst layout, msb to lsb: opcode | rd | rs1_imm | rs2
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = RS2_LSB + RF_SIZE_LOG;
    localparam int RD_LSB  = IMM_LSB + IMM_W;
    localparam int OPC_LSB = RD_LSB + RF_SIZE_LOG;

    typedef enum logic [OPC_W-1:0] {
        OP_LI  = 4'd1,
        OP_ADD = 4'd2,
        OP_MUL = 4'd3,
        OP_LD  = 4'd4,
        OP_BR  = 4'd5
    } opcode_e;

    typedef struct packed {
`ifdef DECODE_ILLEGAL_EN
        logic                     illegal;
`endif
        logic [OPC_W-1:0]         opcode;
        logic                     rs1_used;
        logic [IMM_W-1:0]         rs1_imm;
        logic [MEMI_SIZE_LOG-1:0] rs1_br_offset;
        logic [RF_SIZE_LOG-1:0]   rs1;
        logic                     rs2_used;
        logic [RF_SIZE_LOG-1:0]   rs2;
        logic                     wen;
        logic [RF_SIZE_LOG-1:0]   rd;
        logic                     rd_data_use_alu;
        logic                     mem_valid;
        logic                     is_br;
    } dec_t;

`ifdef DECODE_ILLEGAL_EN
    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return op inside {OP_LI, OP_ADD, OP_MUL, OP_LD, OP_BR};
    endfunction
`endif

endpackage

// File: rtl/decode_buffer_lane.sv
// decode_lane: combinational decode of one raw instruction into buffer-entry fields.
// With DECODE_ILLEGAL_EN, unknown opcodes are flagged and lose their side effects.
module decode_lane
    import decode_buffer_pkg::*;
(
    input  logic [INST_LEN-1:0] inst,
    output dec_t                dec
);

    logic [OPC_W-1:0] opc;
    assign opc = inst[OPC_LSB +: OPC_W];

    always_comb begin
        dec               = '0;
        dec.opcode        = opc;
        dec.rs1_imm       = inst[IMM_LSB +: IMM_W];
        dec.rs1           = inst[IMM_LSB +: RF_SIZE_LOG];
        dec.rs1_br_offset = inst[IMM_LSB +: MEMI_SIZE_LOG];
        dec.rs2           = inst[RS2_LSB +: RF_SIZE_LOG];
        dec.rd            = inst[RD_LSB +: RF_SIZE_LOG];
        case (opc)
            OP_LI: begin
                dec.wen             = 1'b1;
                dec.rd_data_use_alu = 1'b1;
            end
            OP_ADD, OP_MUL: begin
                dec.rs1_used        = 1'b1;
                dec.rs2_used        = 1'b1;
                dec.wen             = 1'b1;
                dec.rd_data_use_alu = 1'b1;
            end
            OP_LD: begin
                dec.rs1_used  = 1'b1;
                dec.wen       = 1'b1;
                dec.mem_valid = 1'b1;
            end
            OP_BR: begin
                dec.rs2_used = 1'b1;
                dec.is_br    = 1'b1;
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = !is_legal(opc);
        if (dec.illegal) begin
            dec.wen       = 1'b0;
            dec.mem_valid = 1'b0;
            dec.is_br     = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/decode_buffer.sv
// decode_buffer: multi-lane circular buffer that decodes on enqueue and presents
// WIDTH decoded lanes with intra-group dependency flags. Option: DECODE_ILLEGAL_EN.
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int WIDTH = DECODE_WIDTH,
    parameter int DEPTH = DECODE_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [$clog2(WIDTH+1)-1:0]            in_count,
    input  logic [WIDTH*INST_LEN-1:0]             in_inst,
    input  logic [WIDTH*MEMI_SIZE_LOG-1:0]        in_pc,
    output logic                                  in_ready,
    output logic [WIDTH-1:0]                      out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0][OPC_W-1:0]           out_opcode,
    output logic [WIDTH-1:0]                      out_rs1_used,
    output logic [WIDTH-1:0][IMM_W-1:0]           out_rs1_imm,
    output logic [WIDTH-1:0][MEMI_SIZE_LOG-1:0]   out_rs1_br_offset,
    output logic [WIDTH-1:0][RF_SIZE_LOG-1:0]     out_rs1,
    output logic [WIDTH-1:0]                      out_rs2_used,
    output logic [WIDTH-1:0][RF_SIZE_LOG-1:0]     out_rs2,
    output logic [WIDTH-1:0]                      out_wen,
    output logic [WIDTH-1:0][RF_SIZE_LOG-1:0]     out_rd,
    output logic [WIDTH-1:0]                      out_rd_data_use_alu,
    output logic [WIDTH-1:0]                      out_mem_valid,
    output logic [WIDTH-1:0]                      out_is_br,
    output logic [WIDTH-1:0][MEMI_SIZE_LOG-1:0]   out_pc,
    output logic [WIDTH-1:0]                      out_dep_rs1,
    output logic [WIDTH-1:0]                      out_dep_rs2,
    output logic [WIDTH-1:0]                      out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WIDTH+1);

    dec_t                     lane_dec [WIDTH];
    dec_t                     dec_mem  [DEPTH];
    logic [MEMI_SIZE_LOG-1:0] pc_mem   [DEPTH];
    dec_t                     out_dec  [WIDTH];

    logic [PTR_W-1:0] head, tail;
    logic [OCC_W-1:0] occ, n_out, enq_cnt, deq_cnt;
    logic             enq, deq;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        decode_lane u_decode_lane (
            .inst (in_inst[g*INST_LEN +: INST_LEN]),
            .dec  (lane_dec[g])
        );
    end

    assign in_ready = (occ <= OCC_W'(DEPTH - WIDTH));
    assign enq      = in_ready && (in_count != '0) && !flush;
    assign deq      = out_ready && out_valid[0];
    assign n_out    = (occ > OCC_W'(WIDTH)) ? OCC_W'(WIDTH) : occ;
    assign enq_cnt  = enq ? OCC_W'(in_count) : '0;
    assign deq_cnt  = deq ? n_out : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            tail <= tail + PTR_W'(enq_cnt);
            head <= head + PTR_W'(deq_cnt);
            occ  <= occ + enq_cnt - deq_cnt;
        end
    end

    // payload storage is deliberately unreset; validity comes only from occ
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (CNT_W'(k) < in_count) begin
                    dec_mem[tail + PTR_W'(k)] <= lane_dec[k];
                    pc_mem[tail + PTR_W'(k)]  <= in_pc[k*MEMI_SIZE_LOG +: MEMI_SIZE_LOG];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            out_valid[k]           = (occ > OCC_W'(k));
            out_dec[k]             = dec_mem[head + PTR_W'(k)];
            out_pc[k]              = pc_mem[head + PTR_W'(k)];
            out_opcode[k]          = out_dec[k].opcode;
            out_rs1_used[k]        = out_dec[k].rs1_used;
            out_rs1_imm[k]         = out_dec[k].rs1_imm;
            out_rs1_br_offset[k]   = out_dec[k].rs1_br_offset;
            out_rs1[k]             = out_dec[k].rs1;
            out_rs2_used[k]        = out_dec[k].rs2_used;
            out_rs2[k]             = out_dec[k].rs2;
            out_wen[k]             = out_dec[k].wen;
            out_rd[k]              = out_dec[k].rd;
            out_rd_data_use_alu[k] = out_dec[k].rd_data_use_alu;
            out_mem_valid[k]       = out_dec[k].mem_valid;
            out_is_br[k]           = out_dec[k].is_br;
`ifdef DECODE_ILLEGAL_EN
            out_illegal[k]         = out_dec[k].illegal;
`else
            out_illegal[k]         = 1'b0;
`endif
        end
    end

    // a source depends on any older lane in the same group that writes its register
    always_comb begin
        out_dep_rs1 = '0;
        out_dep_rs2 = '0;
        for (int k = 1; k < WIDTH; k++) begin
            for (int j = 0; j < k; j++) begin
                if (out_valid[k] && out_valid[j] && out_dec[j].wen) begin
                    if (out_dec[k].rs1_used && (out_dec[j].rd == out_dec[k].rs1))
                        out_dep_rs1[k] = 1'b1;
                    if (out_dec[k].rs2_used && (out_dec[j].rd == out_dec[k].rs2))
                        out_dep_rs2[k] = 1'b1;
                end
            end
        end
    end

endmodule
